// File: rtl/instr_fetch_unit_if.sv
// Instruction-port bundle between the fetch unit (master) and instruction memory (slave).
// Acknowledge and read data are valid in the same cycle.
interface instr_fetch_unit_if;
  logic        iport_req_o;
  logic [31:0] iport_addr_o;
  logic        iport_ack_i;
  logic [31:0] iport_data_i;

  modport master (output iport_req_o, iport_addr_o, input  iport_ack_i, iport_data_i);
  modport slave  (input  iport_req_o, iport_addr_o, output iport_ack_i, iport_data_i);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, runs the instruction-port handshake, feeds decode via a
// 1-entry skid buffer and handles redirects. Optional misaligned-target trap: IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0001_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               jump_i,
  input  logic [31:0]        jump_addr_i,
  output logic [31:0]        instr_o,
  output logic [31:0]        pc_o,
  output logic               instr_valid_o,
  output logic               fetch_err_o,
  instr_fetch_unit_if.master iport
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DISCARD
`ifdef IFU_MISALIGN_CHECK_EN
    , S_ERR
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        ack;
  logic        consume;
  logic [31:0] jump_target;
  state_e      jump_state;
  state_e      discard_exit;

  assign ack     = iport.iport_ack_i;
  assign consume = valid_q & ~stall_i;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misaligned;
  logic err_pend_q, err_pend_d;
  logic fetch_err_q;

  // A misaligned target is never fetched, so its low bits are irrelevant.
  assign misaligned   = |jump_addr_i[1:0];
  assign jump_target  = jump_addr_i;
  assign jump_state   = misaligned ? S_ERR : S_FETCH;
  assign discard_exit = err_pend_q ? S_ERR : S_FETCH;
  assign fetch_err_o  = fetch_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_pend_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      err_pend_q  <= err_pend_d;
      fetch_err_q <= jump_i & misaligned;
    end
  end
`else
  assign jump_target  = jump_addr_i & 32'hFFFF_FFFC;
  assign jump_state   = S_FETCH;
  assign discard_exit = S_FETCH;
  assign fetch_err_o  = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    redirect_pc_d = redirect_pc_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
    err_pend_d    = err_pend_q;
`endif

    if (jump_i) begin
      // Redirect outranks stall and ack: decode output and skid are flushed unconditionally.
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      case (state_q)
        S_FETCH: begin
          if (ack) begin
            fetch_pc_d = jump_target;
            state_d    = jump_state;
          end else begin
            inflight_pc_d = fetch_pc_q;
            redirect_pc_d = jump_target;
`ifdef IFU_MISALIGN_CHECK_EN
            err_pend_d    = misaligned;
`endif
            state_d       = S_DISCARD;
          end
        end
        S_DISCARD: begin
          // Latest redirect wins; if the stale fetch completes now, go straight to it.
          if (ack) begin
            fetch_pc_d = jump_target;
            state_d    = jump_state;
          end else begin
            redirect_pc_d = jump_target;
`ifdef IFU_MISALIGN_CHECK_EN
            err_pend_d    = misaligned;
`endif
          end
        end
        default: begin
          fetch_pc_d = jump_target;
          state_d    = jump_state;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (ack) begin
            if (!valid_q || consume) begin
              instr_d = iport.iport_data_i;
              pc_d    = fetch_pc_q;
              valid_d = 1'b1;
            end else begin
              skid_instr_d = iport.iport_data_i;
              skid_pc_d    = fetch_pc_q;
              state_d      = S_HOLD;
            end
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else if (consume) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end
        end
        S_HOLD: begin
          if (consume) begin
            instr_d = skid_instr_q;
            pc_d    = skid_pc_q;
            state_d = S_FETCH;
          end
        end
        S_DISCARD: begin
          if (ack) begin
            fetch_pc_d = redirect_pc_q;
            state_d    = discard_exit;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pc_q          <= 32'd0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      redirect_pc_q <= redirect_pc_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
    end
  end

  // NOTE: skid payload has no reset; it is only read in HOLD, which is entered after a write.
  always_ff @(posedge clk_i) begin
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

  assign iport.iport_req_o  = (state_q == S_FETCH) || (state_q == S_DISCARD);
  assign iport.iport_addr_o = (state_q == S_DISCARD) ? inflight_pc_q : fetch_pc_q;

  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized run checked
// against a stream-level model of what decode must observe.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0001_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic [31:0] JMASK = 32'hFFFF_FFFC;
`else
  localparam logic [31:0] JMASK = 32'hFFFF_FFFF;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic [31:0] instr_o, pc_o;
  logic        instr_valid_o, fetch_err_o;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .jump_i       (jump_i),
    .jump_addr_i  (jump_addr_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .instr_valid_o(instr_valid_o),
    .fetch_err_o  (fetch_err_o),
    .iport        (bus)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: word at addr reads as addr ^ KEY after a configurable number of wait states.
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = 32'd0;
  logic        stray_ack = 1'b0;
  int          mem_cnt = 0;
  int          cur_ws = 0;
  int          fixed_ws = 0;
  bit          rand_ws = 1'b0;

  assign bus.iport_ack_i  = mem_ack | stray_ack;
  assign bus.iport_data_i = mem_data;

  always @(negedge clk_i) begin
    if (rst_i) begin
      mem_ack = 1'b0;
      mem_cnt = 0;
      cur_ws  = fixed_ws;
    end else if (bus.iport_req_o && mem_cnt >= cur_ws) begin
      mem_ack  = 1'b1;
      mem_data = bus.iport_addr_o ^ KEY;
      mem_cnt  = 0;
      cur_ws   = rand_ws ? int'($urandom_range(0, 2)) : fixed_ws;
    end else begin
      mem_ack = 1'b0;
      mem_cnt = bus.iport_req_o ? mem_cnt + 1 : 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_reset(input int ws);
    fixed_ws = ws;
    rand_ws  = 1'b0;
    stall_i  = 1'b0;
    jump_i   = 1'b0;
    rst_i    = 1'b1;
    repeat (2) step();
    rst_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!instr_valid_o && n < budget) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(instr_valid_o), 32'd1);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] prev_addr;
  bit          prev_jump, prev_req, prev_ack;
  int          n_consumed;

  initial begin
    // Reset values
    rst_i = 1'b1;
    fixed_ws = 0;
    repeat (2) step();
    check("rst_instr", instr_o, NOP);
    check("rst_pc", pc_o, 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_req", 32'(bus.iport_req_o), 32'd0);
    check("rst_err", 32'(fetch_err_o), 32'd0);
    rst_i = 1'b0;

    // Zero-wait streaming from RESET_PC
    step();
    check("t1_req0", 32'(bus.iport_req_o), 32'd1);
    check("t1_addr0", bus.iport_addr_o, RESET_PC);
    check("t1_valid0", 32'(instr_valid_o), 32'd0);
    step();
    check("t1_addr1", bus.iport_addr_o, RESET_PC + 32'd4);
    check("t1_valid1", 32'(instr_valid_o), 32'd1);
    check("t1_pc1", pc_o, RESET_PC);
    check("t1_instr1", instr_o, RESET_PC ^ KEY);
    step();
    check("t1_addr2", bus.iport_addr_o, RESET_PC + 32'd8);
    check("t1_pc2", pc_o, RESET_PC + 32'd4);

    // Stall for three cycles while the 0x..08 fetch is acked into the skid
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_req_hold", 32'(bus.iport_req_o), 32'd0);
      check("t2_pc_hold", pc_o, RESET_PC + 32'd4);
      check("t2_instr_hold", instr_o, (RESET_PC + 32'd4) ^ KEY);
    end
    stall_i = 1'b0;
    step();
    check("t2_pc_skid", pc_o, RESET_PC + 32'd8);
    check("t2_instr_skid", instr_o, (RESET_PC + 32'd8) ^ KEY);
    check("t2_addr_resume", bus.iport_addr_o, RESET_PC + 32'd12);
    step();
    check("t2_pc_next", pc_o, RESET_PC + 32'd12);

    // Jump coinciding with an ack while decode is stalled
    stall_i = 1'b1;
    jump_i = 1'b1;
    jump_addr_i = 32'h0003_0000;
    step();
    jump_i = 1'b0;
    stall_i = 1'b0;
    check("t4_valid", 32'(instr_valid_o), 32'd0);
    check("t4_instr_nop", instr_o, NOP);
    check("t4_addr", bus.iport_addr_o, 32'h0003_0000);
    step();
    check("t4_pc", pc_o, 32'h0003_0000);
    check("t4_instr", instr_o, 32'h0003_0000 ^ KEY);

    // PC wrap at the top of the address space
    jump_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFF8;
    step();
    jump_i = 1'b0;
    check("wrap_addr0", bus.iport_addr_o, 32'hFFFF_FFF8);
    step();
    check("wrap_addr1", bus.iport_addr_o, 32'hFFFF_FFFC);
    step();
    check("wrap_addr2", bus.iport_addr_o, 32'h0000_0000);
    check("wrap_pc1", pc_o, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", pc_o, 32'h0000_0000);

    // Jump while a 2-wait-state fetch is outstanding
    do_reset(2);
    step();
    wait_valid("t3_first", 10);
    check("t3_pc0", pc_o, RESET_PC);
    check("t3_addr_pending", bus.iport_addr_o, RESET_PC + 32'd4);
    jump_i = 1'b1;
    jump_addr_i = 32'h0002_0000;
    step();
    jump_i = 1'b0;
    check("t3_valid_e", 32'(instr_valid_o), 32'd0);
    check("t3_addr_e", bus.iport_addr_o, RESET_PC + 32'd4);
    check("t3_req_e", 32'(bus.iport_req_o), 32'd1);
    step();
    check("t3_valid_f", 32'(instr_valid_o), 32'd0);
    check("t3_addr_f", bus.iport_addr_o, RESET_PC + 32'd4);
    step();
    check("t3_valid_g", 32'(instr_valid_o), 32'd0);
    check("t3_addr_g", bus.iport_addr_o, 32'h0002_0000);
    wait_valid("t3_target", 10);
    check("t3_pc_target", pc_o, 32'h0002_0000);
    check("t3_instr_target", instr_o, 32'h0002_0000 ^ KEY);

    // Asynchronous reset in the middle of a wait-state fetch
    rst_i = 1'b1;
    #1;
    check("t5_instr", instr_o, NOP);
    check("t5_pc", pc_o, 32'd0);
    check("t5_valid", 32'(instr_valid_o), 32'd0);
    check("t5_req", 32'(bus.iport_req_o), 32'd0);
    fixed_ws = 3;
    repeat (2) step();
    rst_i = 1'b0;
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    check("t5_stray_ignored", 32'(instr_valid_o), 32'd0);
    check("t5_refetch_addr", bus.iport_addr_o, RESET_PC);
    wait_valid("t5_refetch", 12);
    check("t5_refetch_pc", pc_o, RESET_PC);

    // Misaligned redirect
    do_reset(0);
    step();
    step();
    jump_i = 1'b1;
    jump_addr_i = 32'h0002_0002;
    step();
    jump_i = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    check("t6_err_pulse", 32'(fetch_err_o), 32'd1);
    check("t6_req_err", 32'(bus.iport_req_o), 32'd0);
    check("t6_valid_err", 32'(instr_valid_o), 32'd0);
    step();
    check("t6_err_clear", 32'(fetch_err_o), 32'd0);
    check("t6_req_park", 32'(bus.iport_req_o), 32'd0);
    step();
    check("t6_req_park2", 32'(bus.iport_req_o), 32'd0);
    jump_i = 1'b1;
    jump_addr_i = 32'h0002_0000;
    step();
    jump_i = 1'b0;
    check("t6_resume_req", 32'(bus.iport_req_o), 32'd1);
`else
    check("t6_err_tied", 32'(fetch_err_o), 32'd0);
    check("t6_valid", 32'(instr_valid_o), 32'd0);
`endif
    check("t6_resume_addr", bus.iport_addr_o, 32'h0002_0000);
    wait_valid("t6_resume", 10);
    check("t6_resume_pc", pc_o, 32'h0002_0000);

    // Randomized run: decode must see an unbroken +4 stream from each redirect target
    do_reset(0);
    rand_ws    = 1'b1;
    exp_pc     = RESET_PC;
    prev_jump  = 1'b0;
    prev_req   = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = 32'd0;
    n_consumed = 0;
    for (int c = 0; c < 800; c++) begin
      step();
      if (prev_jump) check("rnd_flush", 32'(instr_valid_o), 32'd0);
      if (instr_valid_o) begin
        check("rnd_pc", pc_o, exp_pc);
        check("rnd_instr", instr_o, exp_pc ^ KEY);
      end else begin
        check("rnd_nop", instr_o, NOP);
      end
      if (prev_req && !prev_ack) begin
        check("rnd_req_hold", 32'(bus.iport_req_o), 32'd1);
        check("rnd_addr_hold", bus.iport_addr_o, prev_addr);
      end
      check("rnd_align", 32'(bus.iport_addr_o[1:0]), 32'd0);
      check("rnd_err", 32'(fetch_err_o), 32'd0);

      stall_i     = ($urandom_range(0, 3) == 0);
      jump_i      = ($urandom_range(0, 19) == 0);
      jump_addr_i = $urandom & JMASK;
      if (jump_i) begin
        exp_pc = jump_addr_i & 32'hFFFF_FFFC;
      end else if (instr_valid_o && !stall_i) begin
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
      prev_jump = jump_i;
      prev_req  = bus.iport_req_o;
      prev_ack  = bus.iport_ack_i;
      prev_addr = bus.iport_addr_o;
    end
    jump_i  = 1'b0;
    stall_i = 1'b0;
    check("rnd_progress", 32'(n_consumed > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end stage of the atom core that sits directly upstream of the instruction decoder. It owns the fetch PC and runs a req/ack handshake on the instruction port. It delivers one registered instruction plus its PC per cycle to decode, with a valid qualifier. It absorbs downstream stalls through a 1-entry skid buffer and handles jump/branch redirects from execute, including discarding an in-flight fetch.

Parameters:
RESET_PC, 32'h0001_0000, address of the first fetch after reset
NOP_INSTR, 32'h0000_0013, value driven on instr_o while invalid (addi x0,x0,0)

Ports:
clk_i  in  1  core clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
stall_i  in  1  decode cannot accept; holds instr_o/pc_o
jump_i  in  1  redirect request from execute (taken branch/jump)
jump_addr_i  in  32  redirect target
instr_o  out  32  instruction to decode
pc_o  out  32  PC of instr_o
instr_valid_o  out  1  instr_o/pc_o hold a live instruction
iport_req_o  out  1  instruction-port request
iport_addr_o  out  32  instruction-port address, word aligned
iport_ack_i  in  1  port response valid; data valid same cycle
iport_data_i  in  32  fetched instruction word
fetch_err_o  out  1  misaligned redirect target (optional feature, else 0)

Behaviour:
- Reset (async, any time incl. mid-transaction): state=IDLE; fetch_pc=RESET_PC; instr_o=NOP_INSTR; pc_o=0; instr_valid_o=0; skid empty; fetch_err_o=0. A pending bus ack after reset is ignored.
- consume = instr_valid_o & ~stall_i.
- iport_req_o = (state==FETCH | state==DISCARD). iport_addr_o = fetch_pc in FETCH, inflight_pc in DISCARD. Once raised, req and addr stay stable until ack.
- IDLE: req=0. Goes to FETCH the cycle after reset release.
- FETCH, ack & ~jump_i:
  - If ~instr_valid_o | consume: instr_o<=data, pc_o<=fetch_pc, valid<=1.
  - Otherwise: skid<=data/fetch_pc, go HOLD.
  - Both cases: fetch_pc<=fetch_pc+4 (32-bit wrap; 0xFFFF_FFFC+4 = 0).
- FETCH, ~ack: if consume, valid<=0; instr_o<=NOP_INSTR.
- HOLD: req=0. On consume: instr_o/pc_o<=skid, skid empties, go FETCH.
- Redirect. jump_i has priority over stall_i and ack. It always clears valid and skid next cycle; instr_o<=NOP_INSTR. Per state:
  - FETCH with ack same cycle: data dropped, fetch_pc<=target, stay FETCH.
  - FETCH without ack: inflight_pc<=fetch_pc, redirect_pc<=target, go DISCARD.
  - HOLD or IDLE: fetch_pc<=target, go FETCH.
  - DISCARD: redirect_pc<=target (latest wins).
- DISCARD: holds req until ack. Acked data is dropped, fetch_pc<=redirect_pc, go FETCH.
- Latency: redirect target appears on iport_addr_o 1 cycle after jump_i (no outstanding request). Instruction appears on instr_o 1 cycle after ack. Throughput is 1 instr/cycle with zero-wait memory.
- First fetch: RESET_PC on iport_addr_o in the 2nd cycle after reset release.

Optional Feature:
IFU_MISALIGN_CHECK_EN
- Defined: a redirect with jump_addr_i[1:0]!=0 pulses fetch_err_o for 1 cycle (cycle after jump_i) and flushes as a normal redirect. The target is not fetched. If a request is in flight, DISCARD completes first. The unit then sits in ERR (req=0, valid=0) until the next jump_i, which is handled as from IDLE.
- Undefined: jump_addr_i[1:0] forced to 0; fetch_err_o tied 0; no ERR state.

Test Plan:
- Reset release, zero-wait memory returning addr^0xA5A5_0000 -> iport_addr_o 0x0001_0000, 0x0001_0004, 0x0001_0008 on consecutive cycles; instr_valid_o first high in cycle 3; pc_o tracks each word.
- stall_i high 3 cycles while ack arrives -> skid captures word at 0x0001_0008; req low during HOLD; after release decode sees 0x..04 then 0x..08 in order, no loss or duplication.
- jump_i=1, jump_addr_i=0x0002_0000 while 2-wait-state fetch of 0x0001_0004 is outstanding -> addr held at 0x0001_0004 until ack; data dropped; next req addr 0x0002_0000; valid low in between.
- jump_i and ack in same cycle, stall_i=1 -> acked word dropped; next addr = target; instr_valid_o=0 next cycle.
- rst_i asserted mid-wait-state -> all outputs at reset values that cycle; refetch starts at 0x0001_0000.
- (IFU_MISALIGN_CHECK_EN) jump to 0x0002_0002 -> fetch_err_o pulses 1 cycle; no req issued; next jump to 0x0002_0000 resumes fetch.
